// File: rtl/note_pkg.sv
// note_pkg: shared hit-zone size, offset codes and judge score codes.
//   Imported by note_lane_engine and the button judge.
package note_pkg;
  localparam int ZONE_LEN = 5;
  localparam logic [2:0] OFS_NONE    = 3'd0;
  localparam logic [2:0] OFS_EARLY   = 3'd1;
  localparam logic [2:0] OFS_PERF_LO = 3'd2;
  localparam logic [2:0] OFS_PERF_HI = 3'd4;
  localparam logic [2:0] OFS_LATE    = 3'd5;
  typedef enum logic [1:0] {SCORE_NONE, SCORE_MISS, SCORE_GOOD, SCORE_PERFECT} score_e;
  // Timing code of a head note sitting at hit-zone position head (0..ZONE_LEN-1).
  function automatic logic [2:0] ofs_of(input logic [2:0] head);
    return 3'(ZONE_LEN) - head;
  endfunction
endpackage

// File: rtl/step_timer.sv
// step_timer: scroll step generator.
//   Ports: clk, rst (async active-low), run (1 = count, 0 = hold),
//   step_pulse (one cycle every STEP_CYCLES counted cycles).
module step_timer #(
  parameter int STEP_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic step_pulse
);
  localparam int CW = $clog2(STEP_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    step_pulse = run && (cnt_q == CW'(STEP_CYCLES - 1));
    cnt_d = step_pulse ? '0 : cnt_q + CW'(run);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: red/blue note lanes scrolling toward the hit edge; feeds the judge.
//   Ports: clk, rst (async active-low), run; spawn_valid/red/blue + spawn_ready handshake;
//   delete_note (judge hit, one cycle late); node_R/node_B/offset head decode;
//   lane_red/lane_blue bitmaps (bit i = position i); step_pulse; miss.
//   Optional: define NOTE_LANE_MISS_CNT_EN to add saturating miss_count[7:0].
module note_lane_engine
  import note_pkg::*;
#(
  parameter int LANE_LEN    = 8,
  parameter int STEP_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                spawn_valid,
  input  logic                spawn_red,
  input  logic                spawn_blue,
  output logic                spawn_ready,
  input  logic                delete_note,
  output logic                node_R,
  output logic                node_B,
  output logic [2:0]          offset,
  output logic [LANE_LEN-1:0] lane_red,
  output logic [LANE_LEN-1:0] lane_blue,
`ifdef NOTE_LANE_MISS_CNT_EN
  output logic [7:0]          miss_count,
`endif
  output logic                step_pulse,
  output logic                miss
);
  logic                step;
  logic [LANE_LEN-1:0] lane_red_q, lane_red_d, lane_blue_q, lane_blue_d;
  logic [LANE_LEN-1:0] del_mask, red_k, blue_k;
  logic                pend_q, pend_d, pend_red_q, pend_red_d, pend_blue_q, pend_blue_d;
  logic [2:0]          head, prev_head_q, target;
  logic                head_valid, prev_valid_q, prev_step_q, del_ok, accept;

  step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_pulse(step)
  );

  always_comb begin
    head = '0;
    head_valid = 1'b0;
    for (int i = ZONE_LEN - 1; i >= 0; i--)
      if (lane_red_q[i] | lane_blue_q[i]) begin
        head = 3'(i);
        head_valid = 1'b1;
      end
    offset = head_valid ? ofs_of(head) : OFS_NONE;
    node_R = head_valid & lane_red_q[head];
    node_B = head_valid & lane_blue_q[head];
    // The judge answers about last cycle's head; if a step happened since, that note moved down one.
    target = prev_head_q - 3'(prev_step_q);
    del_ok = delete_note && prev_valid_q && !(prev_head_q == 3'd0 && prev_step_q);
    del_mask = del_ok ? (LANE_LEN'(1) << target) : '0;
    red_k = lane_red_q & ~del_mask;
    blue_k = lane_blue_q & ~del_mask;
    miss = step && (red_k[0] | blue_k[0]);
    lane_red_d = step ? {pend_red_q, red_k[LANE_LEN-1:1]} : red_k;
    lane_blue_d = step ? {pend_blue_q, blue_k[LANE_LEN-1:1]} : blue_k;
    spawn_ready = !pend_q;
    accept = spawn_valid && spawn_ready;
    // An empty slot still shifts in zeros, so colour bits are cleared whenever the slot empties.
    pend_d = accept | (pend_q & ~step);
    pend_red_d = accept ? spawn_red : (step ? 1'b0 : pend_red_q);
    pend_blue_d = accept ? spawn_blue : (step ? 1'b0 : pend_blue_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_red_q   <= '0;
      lane_blue_q  <= '0;
      pend_q       <= 1'b0;
      pend_red_q   <= 1'b0;
      pend_blue_q  <= 1'b0;
      prev_head_q  <= '0;
      prev_valid_q <= 1'b0;
      prev_step_q  <= 1'b0;
    end else begin
      lane_red_q   <= lane_red_d;
      lane_blue_q  <= lane_blue_d;
      pend_q       <= pend_d;
      pend_red_q   <= pend_red_d;
      pend_blue_q  <= pend_blue_d;
      prev_head_q  <= head;
      prev_valid_q <= head_valid;
      prev_step_q  <= step;
    end
  end

  assign lane_red   = lane_red_q;
  assign lane_blue  = lane_blue_q;
  assign step_pulse = step;

`ifdef NOTE_LANE_MISS_CNT_EN
  logic [7:0] miss_count_q, miss_count_d;
  assign miss_count_d = miss_count_q + 8'(miss && miss_count_q != 8'hff);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) miss_count_q <= '0;
    else miss_count_q <= miss_count_d;
  end
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_note_lane_engine.sv
// tb_note_lane_engine: random stimulus against a note-list reference model of note_lane_engine.
module tb_note_lane_engine;
  localparam int L  = 8;
  localparam int SC = 4;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0;
  logic spawn_valid = 1'b0, spawn_red = 1'b0, spawn_blue = 1'b0, delete_note = 1'b0;
  logic spawn_ready, node_R, node_B, step_pulse, miss;
  logic [2:0] offset;
  logic [L-1:0] lane_red, lane_blue;
`ifdef NOTE_LANE_MISS_CNT_EN
  logic [7:0] miss_count;
`endif
  int checks = 0, errors = 0;
  bit m_red[L], m_blue[L];
  bit m_pend, m_pr, m_pb, m_pv, m_ps;
  int m_cnt, m_ph, m_mc;

  always #5 clk = ~clk;

  note_lane_engine #(.LANE_LEN(L), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .spawn_valid(spawn_valid), .spawn_red(spawn_red), .spawn_blue(spawn_blue),
    .spawn_ready(spawn_ready), .delete_note(delete_note),
    .node_R(node_R), .node_B(node_B), .offset(offset),
    .lane_red(lane_red), .lane_blue(lane_blue),
`ifdef NOTE_LANE_MISS_CNT_EN
    .miss_count(miss_count),
`endif
    .step_pulse(step_pulse), .miss(miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < L; i++) begin
      m_red[i] = 1'b0;
      m_blue[i] = 1'b0;
    end
    {m_pend, m_pr, m_pb, m_pv, m_ps} = '0;
    m_cnt = 0;
    m_ph = 0;
    m_mc = 0;
  endfunction

  function automatic logic [L-1:0] pack(input bit blue);
    logic [L-1:0] v;
    for (int i = 0; i < L; i++) v[i] = blue ? m_blue[i] : m_red[i];
    return v;
  endfunction

  task automatic cycle(input bit r, input bit sv, input bit sr, input bit sb, input bit dn);
    int head;
    bit step, mexp, accept;
    @(negedge clk);
    run = r; spawn_valid = sv; spawn_red = sr; spawn_blue = sb; delete_note = dn;
    #1;
    head = -1;
    for (int i = ZONE() - 1; i >= 0; i--) if (m_red[i] || m_blue[i]) head = i;
    step = r && (m_cnt == SC - 1);
    check("lane_red", lane_red, pack(1'b0));
    check("lane_blue", lane_blue, pack(1'b1));
    check("offset", offset, head < 0 ? 0 : 5 - head);
    check("node_R", node_R, head < 0 ? 1'b0 : m_red[head]);
    check("node_B", node_B, head < 0 ? 1'b0 : m_blue[head]);
    check("spawn_ready", spawn_ready, !m_pend);
    check("step_pulse", step_pulse, step);
    if (dn && m_pv && !(m_ph == 0 && m_ps)) begin
      m_red[m_ph - int'(m_ps)] = 1'b0;
      m_blue[m_ph - int'(m_ps)] = 1'b0;
    end
    mexp = step && (m_red[0] || m_blue[0]);
    check("miss", miss, mexp);
`ifdef NOTE_LANE_MISS_CNT_EN
    check("miss_count", miss_count, m_mc);
`endif
    if (mexp && m_mc < 255) m_mc++;
    accept = sv && !m_pend;
    m_pv = head >= 0;
    m_ph = m_pv ? head : 0;
    m_ps = step;
    if (step) begin
      for (int i = 0; i < L - 1; i++) begin
        m_red[i] = m_red[i+1];
        m_blue[i] = m_blue[i+1];
      end
      m_red[L-1] = m_pend && m_pr;
      m_blue[L-1] = m_pend && m_pb;
      m_pend = 1'b0;
    end
    if (accept) begin
      m_pend = 1'b1;
      m_pr = sr;
      m_pb = sb;
    end
    m_cnt = step ? 0 : m_cnt + int'(r);
  endtask

  function automatic int ZONE();
    return 5;
  endfunction

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", spawn_ready, 1'b1);
    check("rst_offset", offset, 3'd0);
    check("rst_lane", lane_red | lane_blue, 8'h00);
    check("rst_step", step_pulse, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    // Single red note scrolling the full lane with no hit.
    cycle(1, 1, 1, 0, 0);
    repeat (15) cycle(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("plan_lane4", lane_red, 8'h10);
    check("plan_ofs4", offset, 3'd1);
    check("plan_nodes4", {node_R, node_B}, 2'b10);
    repeat (20) cycle(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("plan_empty", lane_red | lane_blue, 8'h00);
    // Frozen lanes.
    cycle(1, 1, 1, 1, 0);
    repeat (10) cycle(1, 0, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 0, 0);
    // Random play.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(negedge clk);
        rst = 1'b0; run = 1'b0; spawn_valid = 1'b0; delete_note = 1'b0;
        #1;
        check("midrst_lane", lane_red | lane_blue, 8'h00);
        check("midrst_ready", spawn_ready, 1'b1);
        m_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      cycle(($urandom % 8) != 0, ($urandom % 3) != 0, $urandom % 2, $urandom % 2, ($urandom % 4) == 0);
    end
`ifdef NOTE_LANE_MISS_CNT_EN
    repeat (1400) cycle(1, 1, 1, 0, 0);
    check("miss_sat", miss_count, 8'd255);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
